exec_datapath: RTL and testbench

- Execute/memory/writeback datapath that consumes the per-instruction control stream of the dependency-check stage:
  - `op_dec`, `imm`, `imm_sel`, `mux_sel_A`/`mux_sel_B`, `mem_en_ex`/`mem_rw_ex`, `mem_mux_sel_dm`, `RW_dm`.
- Holds the 32×32 register file, applies the forwarding selects, runs the ALU, accesses a 256-word data memory and writes results back.
- Sits directly downstream of the dependency-check stage and closes the forwarding loop that stage plans.

---
 rtl/exec_dp_pkg.sv | 42 ++++
 rtl/exec_datapath_if.sv | 45 ++++
 rtl/exec_regfile.sv | 57 +++++
 rtl/exec_datapath.sv | 198 +++++++++++++++++++
 tb/tb_exec_datapath.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_dp_pkg.sv
// ---------------------------------------------------------------------------
// exec_dp_pkg
// Shared definitions for the execute/memory/writeback datapath:
//   - datapath and register-file geometry
//   - ALU operation codes carried on op_dec
//   - forwarding select encodings carried on mux_sel_A / mux_sel_B
//   - immediate sign-extension helper
// ---------------------------------------------------------------------------
package exec_dp_pkg;

  localparam int DATA_W       = 32;   // register / ALU width
  localparam int REG_N        = 32;   // architectural register count
  localparam int REG_AW       = 5;    // register index width
  localparam int OP_W         = 6;    // op_dec width
  localparam int IMM_W        = 16;   // raw immediate width
  localparam int DM_DEPTH_DEF = 256;  // default data-memory depth in words

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 6'b000000,
    OP_SUB    = 6'b000001,
    OP_AND    = 6'b000010,
    OP_OR     = 6'b000011,
    OP_XOR    = 6'b000100,
    OP_SLT    = 6'b000101,
    OP_SLL    = 6'b000110,
    OP_SRL    = 6'b000111,
    OP_PASS_B = 6'b001000
  } alu_op_e;

  // 11 is reserved and behaves like FWD_RF.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_DM  = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return $signed({{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm});
  endfunction

endpackage

// File: rtl/exec_datapath_if.sv
// ---------------------------------------------------------------------------
// exec_datapath_if
// Per-instruction control stream from the dependency-check stage plus the
// writeback observation bus of exec_datapath.
//   D-aligned  : ra_addr, rb_addr, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B
//   EX-aligned : mem_en_ex, mem_rw_ex
//   DM-aligned : mem_mux_sel_dm, RW_dm
//   Outputs    : wb_we, wb_addr, wb_data, ovf
// Modports:
//   master - the control source (drives the stream, observes writeback)
//   slave  - the datapath
// ---------------------------------------------------------------------------
interface exec_datapath_if;
  import exec_dp_pkg::*;

  logic [REG_AW-1:0] ra_addr;
  logic [REG_AW-1:0] rb_addr;
  logic [OP_W-1:0]   op_dec;
  logic [IMM_W-1:0]  imm;
  logic              imm_sel;
  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic              mem_en_ex;
  logic              mem_rw_ex;
  logic              mem_mux_sel_dm;
  logic [REG_AW-1:0] RW_dm;

  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ovf;

  modport master (
    output ra_addr, rb_addr, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
           mem_en_ex, mem_rw_ex, mem_mux_sel_dm, RW_dm,
    input  wb_we, wb_addr, wb_data, ovf
  );

  modport slave (
    input  ra_addr, rb_addr, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B,
           mem_en_ex, mem_rw_ex, mem_mux_sel_dm, RW_dm,
    output wb_we, wb_addr, wb_data, ovf
  );

endinterface

// File: rtl/exec_regfile.sv
// ---------------------------------------------------------------------------
// exec_regfile
// 32 x 32 register file with two asynchronous read ports and one write port.
//   clk, reset       : clock, asynchronous active-high reset (clears R1-R31)
//   ra_addr/ra_data  : read port A
//   rb_addr/rb_data  : read port B
//   we/waddr/wdata   : write port, committed at the rising edge
// R0 reads as zero and ignores writes. A read of the register being written
// in the same cycle returns the incoming write data (write-first).
// ---------------------------------------------------------------------------
module exec_regfile
  import exec_dp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // The bypass is qualified by a non-zero address so an R0 write can never
  // leak into an R0 read.
  always_comb begin
    ra_data = regs[ra_addr];
    if (ra_addr == '0) begin
      ra_data = '0;
    end else if (we && (waddr == ra_addr)) begin
      ra_data = wdata;
    end
  end

  always_comb begin
    rb_data = regs[rb_addr];
    if (rb_addr == '0) begin
      rb_data = '0;
    end else if (we && (waddr == rb_addr)) begin
      rb_data = wdata;
    end
  end

endmodule

// File: rtl/exec_datapath.sv
// ---------------------------------------------------------------------------
// exec_datapath
// Three-stage execute/memory/writeback datapath:
//   D  : register-file read and forwarding select of operands and store data
//   EX : ALU, synchronous data-memory write / read at the end of the cycle
//   DM : writeback select, register-file write at the end of the cycle
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; clears all pipeline registers
//           (NOP-equivalent) and R1-R31. Data memory is not reset.
//   bus   : exec_datapath_if.slave - control stream in, writeback bus out
// Parameter DM_DEPTH: data-memory words, indexed by the low ALU result bits.
// Build option EXEC_DATAPATH_OVF_EN: when defined, signed overflow of ADD/SUB
// is computed in EX, carried into DM and driven on ovf; otherwise ovf is 0.
// No hazard detection: a FWD_EX select while a load sits in EX forwards the
// load address. The upstream dependency-check stage must stall that case.
// ---------------------------------------------------------------------------
module exec_datapath
  import exec_dp_pkg::*;
#(
  parameter int DM_DEPTH = DM_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  exec_datapath_if.slave  bus
);

  localparam int DM_AW = $clog2(DM_DEPTH);

  function automatic logic signed [DATA_W-1:0] fwd_mux(
    input logic [1:0]               sel,
    input logic signed [DATA_W-1:0] rf_val,
    input logic signed [DATA_W-1:0] ex_val,
    input logic signed [DATA_W-1:0] dm_val
  );
    logic signed [DATA_W-1:0] r;
    case (sel)
      FWD_EX:  r = ex_val;
      FWD_DM:  r = dm_val;
      default: r = rf_val;
    endcase
    return r;
  endfunction

  function automatic logic signed [DATA_W-1:0] alu_eval(
    input logic [OP_W-1:0]          op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] r;
    logic [4:0]               sh;
    sh = b[4:0];
    case (op)
      OP_ADD:    r = a + b;
      OP_SUB:    r = a - b;
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_SLT:    r = (a < b) ? DATA_W'(1) : '0;
      OP_SLL:    r = a << sh;
      OP_SRL:    r = $signed($unsigned(a) >> sh);
      OP_PASS_B: r = b;
      default:   r = '0;
    endcase
    return r;
  endfunction

`ifdef EXEC_DATAPATH_OVF_EN
  // Overflow: operands that agree in sign (ADD) or differ in sign (SUB)
  // producing a result whose sign differs from operand A.
  function automatic logic ovf_eval(
    input logic [OP_W-1:0]          op,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic signed [DATA_W-1:0] r
  );
    logic o;
    o = 1'b0;
    if (op == OP_ADD) begin
      o = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    end else if (op == OP_SUB) begin
      o = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    end
    return o;
  endfunction
`endif

  logic signed [DATA_W-1:0] rf_a;
  logic signed [DATA_W-1:0] rf_b;
  logic signed [DATA_W-1:0] opa_p0;
  logic signed [DATA_W-1:0] opb_p0;
  logic signed [DATA_W-1:0] sdata_p0;

  logic [OP_W-1:0]          op_p1;
  logic signed [DATA_W-1:0] opa_p1;
  logic signed [DATA_W-1:0] opb_p1;
  logic signed [DATA_W-1:0] sdata_p1;
  logic signed [DATA_W-1:0] alu_p1;
  logic [DM_AW-1:0]         dm_idx_p1;
  logic                     st_p1;
  logic                     ld_p1;

  logic signed [DATA_W-1:0] alu_p2;
  logic signed [DATA_W-1:0] rdata_p2;
  logic                     mem_en_p2;
  logic                     mem_rw_p2;

  logic signed [DATA_W-1:0] wb_data;
  logic                     wb_we;

  logic [DATA_W-1:0]        dmem [DM_DEPTH];

  exec_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (bus.ra_addr),
    .rb_addr (bus.rb_addr),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .we      (wb_we),
    .waddr   (bus.RW_dm),
    .wdata   (wb_data)
  );

  // ---- D stage: operand and store-data selection ----
  assign opa_p0   = fwd_mux(bus.mux_sel_A, rf_a, alu_p1, wb_data);
  assign sdata_p0 = fwd_mux(bus.mux_sel_B, rf_b, alu_p1, wb_data);
  assign opb_p0   = bus.imm_sel ? sext_imm(bus.imm) : sdata_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_p1    <= '0;
      opa_p1   <= '0;
      opb_p1   <= '0;
      sdata_p1 <= '0;
    end else begin
      op_p1    <= bus.op_dec;
      opa_p1   <= opa_p0;
      opb_p1   <= opb_p0;
      sdata_p1 <= sdata_p0;
    end
  end

  // ---- EX stage: ALU and memory access ----
  assign alu_p1    = alu_eval(op_p1, opa_p1, opb_p1);
  assign dm_idx_p1 = alu_p1[DM_AW-1:0];
  assign st_p1     = bus.mem_en_ex & bus.mem_rw_ex;
  assign ld_p1     = bus.mem_en_ex & ~bus.mem_rw_ex;

  always_ff @(posedge clk) begin
    if (st_p1) begin
      dmem[dm_idx_p1] <= sdata_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_p2    <= '0;
      rdata_p2  <= '0;
      mem_en_p2 <= 1'b0;
      mem_rw_p2 <= 1'b0;
    end else begin
      alu_p2    <= alu_p1;
      mem_en_p2 <= bus.mem_en_ex;
      mem_rw_p2 <= bus.mem_rw_ex;
      if (ld_p1) begin
        rdata_p2 <= $signed(dmem[dm_idx_p1]);
      end
    end
  end

`ifdef EXEC_DATAPATH_OVF_EN
  logic ovf_p1;
  logic ovf_p2;

  assign ovf_p1 = ovf_eval(op_p1, opa_p1, opb_p1, alu_p1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_p2 <= 1'b0;
    end else begin
      ovf_p2 <= ovf_p1;
    end
  end

  assign bus.ovf = ovf_p2;
`else
  assign bus.ovf = 1'b0;
`endif

  // ---- DM stage: writeback ----
  assign wb_data     = bus.mem_mux_sel_dm ? rdata_p2 : alu_p2;
  assign wb_we       = ~(mem_en_p2 & mem_rw_p2);
  assign bus.wb_we   = wb_we;
  assign bus.wb_addr = bus.RW_dm;
  assign bus.wb_data = wb_data;

endmodule

// File: tb/tb_exec_datapath.sv
// ---------------------------------------------------------------------------
// tb_exec_datapath
// Directed instruction stream for exec_datapath. Each issued instruction is
// run through a sequential architectural model (register file + memory, no
// pipeline); its expected writeback is pushed to a scoreboard queue and
// popped when the instruction reaches DM. Inputs are driven on the falling
// edge in their D/EX/DM-aligned slots, outputs sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_exec_datapath;
  import exec_dp_pkg::*;

  typedef struct {
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [5:0]  op;
    logic [15:0] imm;
    logic        imm_sel;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        men;
    logic        mrw;
    logic        mmux;
    logic [4:0]  rw;
  } inst_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  exec_datapath_if bus ();

  exec_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  exp_t        exp_q[$];
  logic [31:0] m_rf  [32];
  logic [31:0] m_mem [256];

  inst_t nop_i;
  inst_t s_d, s_ex, s_dm;
  bit    v_d, v_ex, v_dm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      6'd0: return a + b;
      6'd1: return a - b;
      6'd2: return a & b;
      6'd3: return a | b;
      6'd4: return a ^ b;
      6'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd6: return a << b[4:0];
      6'd7: return a >> b[4:0];
      6'd8: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Architectural execution of one instruction; returns its expected writeback.
  task automatic model_issue(input inst_t in);
    logic [31:0] a, breg, b, res;
    logic [32:0] wide;
    exp_t        e;
    a    = (in.ra == 0) ? 32'd0 : m_rf[in.ra];
    breg = (in.rb == 0) ? 32'd0 : m_rf[in.rb];
    b    = in.imm_sel ? {{16{in.imm[15]}}, in.imm} : breg;
    res  = ref_alu(in.op, a, b);
    e.ovf = 1'b0;
`ifdef EXEC_DATAPATH_OVF_EN
    if (in.op == 6'd0) begin
      wide  = {a[31], a} + {b[31], b};
      e.ovf = wide[32] ^ wide[31];
    end else if (in.op == 6'd1) begin
      wide  = {a[31], a} - {b[31], b};
      e.ovf = wide[32] ^ wide[31];
    end
`else
    wide = '0;
`endif
    e.we   = !(in.men && in.mrw);
    e.addr = in.rw;
    if (in.men && in.mrw) m_mem[res[7:0]] = breg;
    e.data = in.mmux ? m_mem[res[7:0]] : res;
    if (e.we && in.rw != 0) m_rf[in.rw] = e.data;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    bus.ra_addr        = s_d.ra;
    bus.rb_addr        = s_d.rb;
    bus.op_dec         = s_d.op;
    bus.imm            = s_d.imm;
    bus.imm_sel        = s_d.imm_sel;
    bus.mux_sel_A      = s_d.sa;
    bus.mux_sel_B      = s_d.sb;
    bus.mem_en_ex      = s_ex.men;
    bus.mem_rw_ex      = s_ex.mrw;
    bus.mem_mux_sel_dm = s_dm.mmux;
    bus.RW_dm          = s_dm.rw;
  endtask

  task automatic check_dm();
    exp_t e;
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("wb_we",   32'(bus.wb_we),   32'(e.we));
      chk("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
      chk("wb_data", bus.wb_data,      e.data);
      chk("ovf",     32'(bus.ovf),     32'(e.ovf));
    end
  endtask

  task automatic cycle(input inst_t in, input bit vin);
    @(negedge clk);
    s_dm = s_ex; v_dm = v_ex;
    s_ex = s_d;  v_ex = v_d;
    s_d  = in;   v_d  = vin;
    if (vin) model_issue(in);
    drive();
    #1;
    if (v_dm) check_dm();
  endtask

  task automatic issue(input inst_t in);
    cycle(in, 1'b1);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cycle(nop_i, 1'b0);
  endtask

  function automatic inst_t alu_i(input logic [5:0] op, input logic [4:0] ra,
                                  input logic [4:0] rb, input logic [15:0] imm,
                                  input logic imm_sel, input logic [1:0] sa,
                                  input logic [1:0] sb, input logic [4:0] rw);
    inst_t r;
    r = '{default: '0};
    r.op = op; r.ra = ra; r.rb = rb; r.imm = imm; r.imm_sel = imm_sel;
    r.sa = sa; r.sb = sb; r.rw = rw;
    return r;
  endfunction

  function automatic inst_t st_i(input logic [15:0] idx, input logic [4:0] rb,
                                 input logic [1:0] sb);
    inst_t r;
    r = alu_i(6'd0, 5'd0, rb, idx, 1'b1, 2'b00, sb, 5'd0);
    r.men = 1'b1; r.mrw = 1'b1;
    return r;
  endfunction

  function automatic inst_t ld_i(input logic [15:0] idx, input logic [4:0] rw);
    inst_t r;
    r = alu_i(6'd0, 5'd0, 5'd0, idx, 1'b1, 2'b00, 2'b00, rw);
    r.men = 1'b1; r.mmux = 1'b1;
    return r;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},   32'(bus.wb_we),   32'd1);
    chk({tag, "_addr"}, 32'(bus.wb_addr), 32'd0);
    chk({tag, "_data"}, bus.wb_data,      32'd0);
    chk({tag, "_ovf"},  32'(bus.ovf),     32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nop_i = '{default: '0};
    s_d = nop_i; s_ex = nop_i; s_dm = nop_i;
    v_d = 0; v_ex = 0; v_dm = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    drive();

    // Power-on reset
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // R1 = 5, then read R1 back
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'd5, 1'b1, 2'b00, 2'b00, 5'd1));
    nop(2);
    issue(alu_i(6'd0, 5'd1, 5'd0, 16'd0, 1'b1, 2'b00, 2'b00, 5'd7));
    // SUB R2 = R1 - R1; ADD R3 = R2 + 7 forwarded from EX
    issue(alu_i(6'd1, 5'd1, 5'd1, 16'd0, 1'b0, 2'b00, 2'b00, 5'd2));
    issue(alu_i(6'd0, 5'd2, 5'd0, 16'd7, 1'b1, 2'b01, 2'b00, 5'd3));
    // Store R1 to [3], load [3] into R4 next cycle
    issue(st_i(16'd3, 5'd1, 2'b00));
    issue(ld_i(16'd3, 5'd4));
    // Write-first: R6 = 9 in DM while D reads R6 from the register file
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'd9, 1'b1, 2'b00, 2'b00, 5'd6));
    nop(1);
    issue(alu_i(6'd0, 5'd6, 5'd0, 16'd0, 1'b0, 2'b00, 2'b00, 5'd8));
    // R0 write of 0x1234 is discarded, including from the bypass
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'h1234, 1'b1, 2'b00, 2'b00, 5'd0));
    nop(1);
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'd1, 1'b1, 2'b00, 2'b00, 5'd9));
    nop(2);
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'd2, 1'b1, 2'b00, 2'b00, 5'd10));

    // Remaining ALU operations
    issue(alu_i(6'd2, 5'd1, 5'd0, 16'h000C, 1'b1, 2'b00, 2'b00, 5'd11));
    issue(alu_i(6'd3, 5'd1, 5'd0, 16'h000A, 1'b1, 2'b00, 2'b00, 5'd12));
    issue(alu_i(6'd4, 5'd1, 5'd0, 16'hFFFF, 1'b1, 2'b00, 2'b00, 5'd13));
    issue(alu_i(6'd5, 5'd1, 5'd0, 16'hFFFF, 1'b1, 2'b00, 2'b00, 5'd14));
    issue(alu_i(6'd5, 5'd0, 5'd0, 16'd1,    1'b1, 2'b00, 2'b00, 5'd15));
    issue(alu_i(6'd5, 5'd13, 5'd1, 16'd0,   1'b0, 2'b00, 2'b00, 5'd16));
    issue(alu_i(6'd6, 5'd1, 5'd0, 16'h0024, 1'b1, 2'b00, 2'b00, 5'd17));
    issue(alu_i(6'd7, 5'd13, 5'd0, 16'd28,  1'b1, 2'b00, 2'b00, 5'd18));
    issue(alu_i(6'd8, 5'd0, 5'd0, 16'h8000, 1'b1, 2'b00, 2'b00, 5'd19));
    issue(alu_i(6'h3F, 5'd1, 5'd0, 16'd1,   1'b1, 2'b00, 2'b00, 5'd20));

    // Forwarding from DM and EX, forwarded store data
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'd3, 1'b1, 2'b00, 2'b00, 5'd21));
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'd4, 1'b1, 2'b00, 2'b00, 5'd22));
    issue(alu_i(6'd0, 5'd21, 5'd22, 16'd0, 1'b0, 2'b10, 2'b01, 5'd23));
    issue(st_i(16'd10, 5'd23, 2'b01));
    nop(1);
    issue(ld_i(16'd10, 5'd24));

    // Overflow boundary: 0x7FFFFFFF + 1 and 0x80000000 - 1
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'hFFFF, 1'b1, 2'b00, 2'b00, 5'd25));
    issue(alu_i(6'd7, 5'd25, 5'd0, 16'd1, 1'b1, 2'b01, 2'b00, 5'd26));
    issue(alu_i(6'd0, 5'd26, 5'd0, 16'd1, 1'b1, 2'b01, 2'b00, 5'd27));
    issue(alu_i(6'd1, 5'd27, 5'd0, 16'd1, 1'b1, 2'b01, 2'b00, 5'd28));
    nop(3);

    // Reset with three instructions in flight
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'h0011, 1'b1, 2'b00, 2'b00, 5'd1));
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'h0022, 1'b1, 2'b00, 2'b00, 5'd2));
    issue(alu_i(6'd0, 5'd0, 5'd0, 16'h0033, 1'b1, 2'b00, 2'b00, 5'd3));
    reset = 1'b1;
    s_d = nop_i; s_ex = nop_i; s_dm = nop_i;
    v_d = 0; v_ex = 0; v_dm = 0;
    drive();
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    #1;
    chk_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Registers cleared, memory retained
    issue(alu_i(6'd0, 5'd1, 5'd0, 16'd0, 1'b1, 2'b00, 2'b00, 5'd5));
    issue(alu_i(6'd0, 5'd2, 5'd0, 16'd0, 1'b1, 2'b00, 2'b00, 5'd6));
    issue(alu_i(6'd0, 5'd3, 5'd0, 16'd0, 1'b1, 2'b00, 2'b00, 5'd7));
    issue(alu_i(6'd0, 5'd4, 5'd0, 16'd0, 1'b1, 2'b00, 2'b00, 5'd8));
    issue(ld_i(16'd3, 5'd9));
    issue(ld_i(16'd10, 5'd10));
    nop(3);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
